// File: rtl/apb_multi_accum_if.sv
// APB3 bus bundle for apb_multi_accum; master drives the request, slave drives the response.
interface apb_multi_accum_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_multi_accum.sv
// APB3 slave with NUM_CH accumulator channels (OR/AND/XOR/ADD), wait states,
// sticky carry, saturating op counter and a registered level interrupt.

// One accumulator channel: DATA/CTRL/RESULT/STATUS state and its update rules.
module apb_multi_accum_ch #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_data,
  input  logic              we_ctrl,
  input  logic              we_stat,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rd_ctrl,
  output logic [DATA_W-1:0] rd_result,
  output logic [DATA_W-1:0] rd_status,
  output logic              irq_req
);
  logic [DATA_W-1:0] data_q, result_q, op_res;
  logic [1:0]        op_q;
  logic              irq_en_q, carry_q;
  logic [7:0]        opcnt_q;
  logic [DATA_W:0]   sum;
  logic [31:0]       st;

  assign sum = {1'b0, result_q} + {1'b0, data_q};

  // Result of the op named in the CTRL write being committed (new op applies immediately).
  always_comb begin
    op_res = result_q;
    case (wdata[2:1])
      2'b00: op_res = result_q | data_q;
      2'b01: op_res = result_q & data_q;
      2'b10: op_res = result_q ^ data_q;
      2'b11: op_res = sum[DATA_W-1:0];
      default: op_res = result_q;
    endcase
  end

  // Channel registers; CLR beats START, carry is sticky until W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      result_q <= '0;
      op_q     <= '0;
      irq_en_q <= 1'b0;
      carry_q  <= 1'b0;
      opcnt_q  <= '0;
    end else begin
      if (we_data) data_q <= wdata;
      if (we_ctrl) begin
        op_q     <= wdata[2:1];
        irq_en_q <= wdata[4];
        if (wdata[3]) begin
          result_q <= '0;
        end else if (wdata[0]) begin
          result_q <= op_res;
          if (wdata[2:1] == 2'b11 && sum[DATA_W]) carry_q <= 1'b1;
          if (opcnt_q != 8'hFF) opcnt_q <= opcnt_q + 8'd1;
        end
      end
      if (we_stat && wdata[0]) carry_q <= 1'b0;
    end
  end

  assign st        = {16'b0, opcnt_q, 7'b0, carry_q};
  assign rd_data   = data_q;
  assign rd_ctrl   = DATA_W'({irq_en_q, 1'b0, op_q, 1'b0});
  assign rd_result = result_q;
  assign rd_status = st[DATA_W-1:0];
  assign irq_req   = carry_q & irq_en_q;
endmodule

module apb_multi_accum #(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic               PCLK,
  input  logic               PRESET,
  apb_multi_accum_if.slave   bus,
  output logic               irq
);
  localparam int CH_AW = ADDR_W - 4;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                         state_q, state_d;
  logic [3:0]                     wcnt_q, wcnt_d;
  logic                           done, wr_ok, err;
  logic [CH_AW-1:0]               ch;
  logic [1:0]                     off;
  logic [DATA_W-1:0]              rdata;
  logic [NUM_CH-1:0][DATA_W-1:0]  rd_data, rd_ctrl, rd_result, rd_status;
  logic [NUM_CH-1:0]              irq_req;

  assign ch    = bus.PADDR[ADDR_W-1:4];
  assign off   = bus.PADDR[3:2];
  assign err   = ({1'b0, ch} >= (CH_AW+1)'(NUM_CH)) || (bus.PADDR[1:0] != 2'b00) ||
                 (bus.PWRITE && off == 2'd2);
  assign wr_ok = done && bus.PWRITE && !err;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = wr_ok && (ch == CH_AW'(i));
    apb_multi_accum_ch #(.DATA_W(DATA_W)) u_ch (
      .clk       (PCLK),
      .rst       (PRESET),
      .we_data   (sel && off == 2'd0),
      .we_ctrl   (sel && off == 2'd1),
      .we_stat   (sel && off == 2'd3),
      .wdata     (bus.PWDATA),
      .rd_data   (rd_data[i]),
      .rd_ctrl   (rd_ctrl[i]),
      .rd_result (rd_result[i]),
      .rd_status (rd_status[i]),
      .irq_req   (irq_req[i])
    );
  end

  // Read mux over the addressed channel and register offset.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CH_AW'(i)) begin
        case (off)
          2'd0: rdata = rd_data[i];
          2'd1: rdata = rd_ctrl[i];
          2'd2: rdata = rd_result[i];
          default: rdata = rd_status[i];
        endcase
      end
    end
  end

  // FSM state register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next state: the !PREADY guard keeps the access phase still held during the
  // completion cycle from being taken as a fresh transfer.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (bus.PSEL && bus.PENABLE && !bus.PREADY) begin
        state_d = S_WAIT;
        wcnt_d  = 4'(WAIT_STATES);
      end
      S_WAIT: begin
        if (!(bus.PSEL && bus.PENABLE)) state_d = S_IDLE;
        else if (wcnt_q != 4'd0)        wcnt_d  = wcnt_q - 4'd1;
        else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered APB response; PRDATA only moves on a completed read.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      bus.PREADY  <= 1'b0;
      bus.PSLVERR <= 1'b0;
      bus.PRDATA  <= '0;
    end else begin
      bus.PREADY  <= done;
      bus.PSLVERR <= done && err;
      if (done && !bus.PWRITE) bus.PRDATA <= err ? '0 : rdata;
    end
  end

  // Level interrupt, one cycle behind the channel carry/enable state.
  always_ff @(posedge PCLK) begin
    if (PRESET) irq <= 1'b0;
    else        irq <= |irq_req;
  end
endmodule

// File: tb/tb_apb_multi_accum.sv
// Scoreboard bench for apb_multi_accum: stimulus pushes expectations, a monitor pops on PREADY.
module tb_apb_multi_accum;
  localparam int DW = 32, NCH = 4, AW = 8, WS = 3;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  logic irq;
  int   total = 0, bad = 0;

  apb_multi_accum_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  apb_multi_accum #(.DATA_W(DW), .NUM_CH(NCH), .ADDR_W(AW), .WAIT_STATES(WS)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] rdata;
    bit          rd;
    bit          err;
    string       nm;
  } exp_t;
  exp_t exp_q[$];

  // reference model state
  logic [31:0] m_data[NCH], m_res[NCH];
  logic [1:0]  m_op[NCH];
  bit          m_ien[NCH], m_cy[NCH];
  int          m_cnt[NCH];

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_data[i] = 0; m_res[i] = 0; m_op[i] = 0; m_ien[i] = 0; m_cy[i] = 0; m_cnt[i] = 0;
    end
  endfunction

  function automatic bit model_irq();
    bit r = 0;
    for (int i = 0; i < NCH; i++) r |= m_cy[i] & m_ien[i];
    return r;
  endfunction

  function automatic void model_write(input int c, input int o, input logic [31:0] wd);
    logic [63:0] s;
    case (o)
      0: m_data[c] = wd;
      4: begin
        m_op[c]  = wd[2:1];
        m_ien[c] = wd[4];
        if (wd[3]) m_res[c] = 0;
        else if (wd[0]) begin
          case (m_op[c])
            2'd0: m_res[c] = m_res[c] | m_data[c];
            2'd1: m_res[c] = m_res[c] & m_data[c];
            2'd2: m_res[c] = m_res[c] ^ m_data[c];
            default: begin
              s = {32'b0, m_res[c]} + {32'b0, m_data[c]};
              if (s[32]) m_cy[c] = 1;
              m_res[c] = s[31:0];
            end
          endcase
          if (m_cnt[c] < 255) m_cnt[c]++;
        end
      end
      12: if (wd[0]) m_cy[c] = 0;
      default: ;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_irq(input string nm);
    @(posedge PCLK); #1;
    chk(nm, {31'b0, irq}, {31'b0, model_irq()});
  endtask

  // one APB transfer; expectation goes to the scoreboard, latency checked here
  task automatic apb(input bit wr, input logic [7:0] addr, input logic [31:0] wd, input string nm);
    exp_t e;
    int   c, o, n;
    bit   got;
    c = int'(addr[7:4]);
    o = int'(addr[3:0]);
    e.rd = !wr; e.nm = nm; e.rdata = 0;
    e.err = (c >= NCH) || (addr[1:0] != 2'b00) || (wr && o == 8);
    if (!e.err) begin
      if (!wr) begin
        case (o)
          0: e.rdata = m_data[c];
          4: e.rdata = {27'b0, m_ien[c], 1'b0, m_op[c], 1'b0};
          8: e.rdata = m_res[c];
          default: e.rdata = {16'b0, 8'(m_cnt[c]), 7'b0, m_cy[c]};
        endcase
      end else model_write(c, o, wd);
    end
    exp_q.push_back(e);
    @(posedge PCLK); #1;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wd;
    @(posedge PCLK); #1;
    bus.PENABLE = 1;
    got = 0; n = 0;
    while (!got && n < 20) begin
      @(posedge PCLK); #1;
      n++;
      if (bus.PREADY) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_timeout actual=no_pready required=pready", nm);
      e = exp_q.pop_back();
    end else if (n != WS + 2) begin
      bad++;
      $display("FAIL %s_latency actual=%0d required=%0d", nm, n, WS + 2);
    end
    bus.PSEL = 0; bus.PENABLE = 0;
  endtask

  // monitor: every PREADY must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (bus.PREADY === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pready actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          if (bus.PSLVERR !== e.err || (e.rd && bus.PRDATA !== e.rdata)) begin
            bad++;
            $display("FAIL %s actual=%h/err%b required=%h/err%b", e.nm, bus.PRDATA, bus.PSLVERR,
                     e.rdata, e.err);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] a;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1 PRESET = 0;
    chk("rst_pready", {31'b0, bus.PREADY}, 0);
    chk("rst_pslverr", {31'b0, bus.PSLVERR}, 0);
    chk("rst_prdata", bus.PRDATA, 0);
    chk("rst_irq", {31'b0, irq}, 0);

    // reset readback
    apb(0, 8'h08, 0, "rd_ch0_result");
    apb(0, 8'h3C, 0, "rd_ch3_status");

    // ch1 OR accumulate
    apb(1, 8'h10, 32'hF0F0_0000, "wr_ch1_data");
    apb(1, 8'h14, 32'h1, "wr_ch1_ctrl");
    apb(1, 8'h10, 32'h0000_0F0F, "wr_ch1_data2");
    apb(1, 8'h14, 32'h1, "wr_ch1_ctrl2");
    chk("model_or", m_res[1], 32'hF0F0_0F0F);
    apb(0, 8'h18, 0, "rd_ch1_result");
    apb(0, 8'h1C, 0, "rd_ch1_status");
    apb(0, 8'h14, 0, "rd_ch1_ctrl");

    // ch2 ADD with carry and irq
    apb(1, 8'h20, 32'hFFFF_FFFF, "wr_ch2_data");
    apb(1, 8'h24, 32'h17, "wr_ch2_add1");
    apb(1, 8'h24, 32'h17, "wr_ch2_add2");
    apb(0, 8'h28, 0, "rd_ch2_result");
    apb(0, 8'h2C, 0, "rd_ch2_status");
    apb(0, 8'h24, 0, "rd_ch2_ctrl");
    chk_irq("irq_set");
    apb(1, 8'h2C, 32'h1, "w1c_ch2_status");
    chk("irq_still_high", {31'b0, irq}, 1);
    chk_irq("irq_clear");
    apb(0, 8'h2C, 0, "rd_ch2_status_clr");

    // decode errors
    apb(1, 8'h08, 32'h1234, "err_wr_result");
    apb(0, 8'h42, 0, "err_rd_ch4");
    apb(0, 8'h06, 0, "err_rd_unaligned");
    apb(0, 8'h08, 0, "rd_ch0_result_unchanged");

    // CLR wins over START
    apb(1, 8'h14, 32'h9, "wr_ch1_clr_start");
    apb(0, 8'h18, 0, "rd_ch1_result_clr");
    apb(0, 8'h1C, 0, "rd_ch1_status_clr");

    // OPCNT saturation on ch3 with random ops
    apb(1, 8'h30, $urandom, "wr_ch3_data");
    for (int i = 0; i < 300; i++)
      apb(1, 8'h34, {29'b0, 2'($urandom_range(0, 3)), 1'b1}, "wr_ch3_start");
    apb(0, 8'h3C, 0, "rd_ch3_status_sat");
    apb(0, 8'h38, 0, "rd_ch3_result");
    chk("model_sat", m_cnt[3], 255);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      a = {4'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (a[3:2] == 2'd1) apb($urandom_range(0, 1), a, 32'($urandom_range(0, 31)), "rand_ctrl");
      else                apb($urandom_range(0, 1), a, $urandom, "rand");
    end
    chk_irq("irq_rand");

    // abort in WAIT: no PREADY, no write
    @(posedge PCLK); #1;
    bus.PSEL = 1; bus.PWRITE = 1; bus.PADDR = 8'h00; bus.PWDATA = 32'hDEAD_BEEF;
    @(posedge PCLK); #1 bus.PENABLE = 1;
    @(posedge PCLK);
    @(posedge PCLK); #1 bus.PSEL = 0; bus.PENABLE = 0;
    begin
      bit seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge PCLK); #1;
        if (bus.PREADY) seen = 1;
      end
      chk("abort_no_pready", {31'b0, seen}, 0);
    end
    apb(0, 8'h00, 0, "rd_ch0_data_after_abort");

    // set up nonzero PRDATA and irq, then reset mid-WAIT
    apb(1, 8'h24, 32'h18, "wr_ch2_clr_ien");
    apb(1, 8'h20, 32'hFFFF_FFFF, "wr_ch2_data_b");
    apb(1, 8'h24, 32'h17, "wr_ch2_add_b1");
    apb(1, 8'h24, 32'h17, "wr_ch2_add_b2");
    chk_irq("irq_before_reset");
    apb(0, 8'h28, 0, "rd_ch2_result_b");
    @(posedge PCLK); #1;
    bus.PSEL = 1; bus.PWRITE = 1; bus.PADDR = 8'h00; bus.PWDATA = 32'h55;
    @(posedge PCLK); #1 bus.PENABLE = 1;
    @(posedge PCLK);
    @(posedge PCLK); #1;
    PRESET = 1; bus.PSEL = 0; bus.PENABLE = 0;
    @(posedge PCLK); #1 PRESET = 0;
    model_reset();
    chk("midrst_pready", {31'b0, bus.PREADY}, 0);
    chk("midrst_prdata", bus.PRDATA, 0);
    chk("midrst_irq", {31'b0, irq}, 0);
    for (int c = 0; c < NCH; c++)
      for (int o = 0; o < 4; o++)
        apb(0, 8'(c * 16 + o * 4), 0, "rd_after_midrst");

    repeat (4) @(posedge PCLK);
    #1 chk("queue_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
